// File: rtl/qsn_pkg.sv
// Shared constants, control-word layout, FSM states and the delta/mask helper
// used by the QSN shift scheduler.
package qsn_pkg;

  localparam int Z         = 3;
  localparam int SEL_W     = 2;
  localparam int COL_NUM   = 4;
  localparam int LAYER_NUM = 3;
  localparam int ITER_W    = 4;
  localparam int ADDR_W    = $clog2(LAYER_NUM * COL_NUM);
  localparam int COL_W     = $clog2(COL_NUM);
  localparam int LAYER_W   = $clog2(LAYER_NUM);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } sched_state_e;

  typedef struct packed {
    logic [SEL_W-1:0]   selRight;
    logic [SEL_W-1:0]   selLeft;
    logic [Z-1:0]       mergeMask;
    logic               isNull;
    logic [COL_W-1:0]   col;
    logic [LAYER_W-1:0] layer;
    logic               lastCol;
    logic               lastWord;
  } ctrl_word_t;

  function automatic logic [SEL_W-1:0] modZ(input logic [SEL_W-1:0] v);
    return (v >= SEL_W'(Z)) ? v - SEL_W'(Z) : v;
  endfunction

  function automatic ctrl_word_t buildCtrl(
    input logic [SEL_W:0]     tblWord,
    input logic [SEL_W-1:0]   prevShift,
    input logic [COL_W-1:0]   col,
    input logic [LAYER_W-1:0] layer,
    input logic               lastWord
  );
    ctrl_word_t       w;
    logic [SEL_W:0]   diff;
    logic [SEL_W-1:0] delta;
    logic [SEL_W:0]   keep;
    w    = '0;
    diff = {1'b0, modZ(tblWord[SEL_W-1:0])} - {1'b0, prevShift};
    // A borrow out of the subtraction means the shift wrapped below zero.
    if (diff[SEL_W]) diff = diff + (SEL_W+1)'(Z);
    delta = tblWord[SEL_W] ? '0 : diff[SEL_W-1:0];
    keep  = (SEL_W+1)'(Z) - {1'b0, delta};
    w.selRight = delta;
    w.selLeft  = (delta == '0) ? '0 : keep[SEL_W-1:0];
    for (int i = 0; i < Z; i++) begin
      w.mergeMask[i] = ((SEL_W+1)'(i) < keep);
    end
    w.isNull   = tblWord[SEL_W];
    w.col      = col;
    w.layer    = layer;
    w.lastCol  = (col == COL_W'(COL_NUM - 1));
    w.lastWord = lastWord;
    return w;
  endfunction

endpackage

// File: rtl/qsn_ctrl_skid2.sv
// Two-entry fall-through FIFO for QSN control words; an arriving word passes
// straight to the output when the buffer is empty so throughput stays at one per cycle.
module qsn_ctrl_skid2
  import qsn_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  input  ctrl_word_t in_data_i,
  input  logic       out_ready_i,
  output logic       out_valid_o,
  output ctrl_word_t out_data_o,
  output logic [1:0] count_o
);

  ctrl_word_t mem_q [2];
  logic       wrPtr_q;
  logic       rdPtr_q;
  logic [1:0] count_q;
  logic       empty;
  logic       pop;
  logic       popMem;
  logic       push;

  assign empty       = (count_q == 2'd0);
  assign out_valid_o = !empty || in_valid_i;
  assign out_data_o  = empty ? in_data_i : mem_q[rdPtr_q];
  assign pop         = out_valid_o && out_ready_i;
  assign popMem      = pop && !empty;
  // A word consumed on the bypass path never occupies an entry.
  assign push        = in_valid_i && !(empty && pop);
  assign count_o     = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q  <= 1'b0;
      rdPtr_q  <= 1'b0;
      count_q  <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      if (push) begin
        mem_q[wrPtr_q] <= in_data_i;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (popMem) rdPtr_q <= ~rdPtr_q;
      count_q <= count_q + 2'(push) - 2'(popMem);
    end
  end

  skidNoOverflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(in_valid_i && (count_q == 2'd2)));

endmodule

// File: rtl/qsn_shift_sched.sv
// Walks iterations x layers x columns of the shift table and emits per-column
// QSN select/merge control words through a credit-limited skid buffer.
module qsn_shift_sched
  import qsn_pkg::*;
(
  input  logic               sys_clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [ITER_W-1:0]  iter_num_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               tbl_rd_en_o,
  output logic [ADDR_W-1:0]  tbl_addr_o,
  input  logic [SEL_W:0]     tbl_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [SEL_W-1:0]   sel_right_o,
  output logic [SEL_W-1:0]   sel_left_o,
  output logic [Z-1:0]       merge_mask_o,
  output logic               out_null_o,
  output logic [COL_W-1:0]   col_idx_o,
  output logic [LAYER_W-1:0] layer_idx_o,
  output logic               last_col_o,
  output logic               last_word_o
);

  sched_state_e       state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [ITER_W-1:0]  iterNum_q, iterNum_d;
  logic               rdPend_q;
  logic [COL_W-1:0]   pendCol_q;
  logic [LAYER_W-1:0] pendLayer_q;
  logic               pendLast_q;
  logic [SEL_W-1:0]   prevShift_q [COL_NUM];
  logic [1:0]         skidCount;
  logic               rdEn;
  logic               lastAddr;
  logic               outValid;
  ctrl_word_t         arrWord;
  ctrl_word_t         outWord;

  assign lastAddr = (iter_q == iterNum_q - ITER_W'(1)) &&
                    (layer_q == LAYER_W'(LAYER_NUM - 1)) &&
                    (col_q == COL_W'(COL_NUM - 1));
  // Never let in-flight reads plus buffered words exceed the two skid entries.
  assign rdEn     = (state_q == S_RUN) && (({1'b0, rdPend_q} + skidCount) < 2'd2);
  assign arrWord  = rdPend_q ? buildCtrl(tbl_data_i, prevShift_q[pendCol_q],
                                         pendCol_q, pendLayer_q, pendLast_q)
                             : '0;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    layer_d   = layer_q;
    iter_d    = iter_q;
    iterNum_d = iterNum_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          iterNum_d = iter_num_i;
          col_d     = '0;
          layer_d   = '0;
          iter_d    = '0;
          state_d   = (iter_num_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (rdEn) begin
          if (lastAddr) state_d = S_DRAIN;
          if (col_q == COL_W'(COL_NUM - 1)) begin
            col_d = '0;
            if (layer_q == LAYER_W'(LAYER_NUM - 1)) begin
              layer_d = '0;
              iter_d  = iter_q + ITER_W'(1);
            end else begin
              layer_d = layer_q + LAYER_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      // The last word leaving empties the skid and the read pipe together.
      S_DRAIN: if (outValid && out_ready_i && outWord.lastWord) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      layer_q     <= '0;
      iter_q      <= '0;
      iterNum_q   <= '0;
      rdPend_q    <= 1'b0;
      pendCol_q   <= '0;
      pendLayer_q <= '0;
      pendLast_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      layer_q     <= layer_d;
      iter_q      <= iter_d;
      iterNum_q   <= iterNum_d;
      rdPend_q    <= rdEn;
      pendCol_q   <= col_q;
      pendLayer_q <= layer_q;
      pendLast_q  <= lastAddr;
    end
  end

  // Column history advances on data arrival so consecutive reads see fresh values.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < COL_NUM; c++) prevShift_q[c] <= '0;
    end else if (rdPend_q && !tbl_data_i[SEL_W]) begin
      prevShift_q[pendCol_q] <= modZ(tbl_data_i[SEL_W-1:0]);
    end
  end

  qsn_ctrl_skid2 uSkid (
    .clk_i       (sys_clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (rdPend_q),
    .in_data_i   (arrWord),
    .out_ready_i (out_ready_i),
    .out_valid_o (outValid),
    .out_data_o  (outWord),
    .count_o     (skidCount)
  );

  assign busy_o       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o       = (state_q == S_DONE);
  assign tbl_rd_en_o  = rdEn;
  assign tbl_addr_o   = ADDR_W'(layer_q) * ADDR_W'(COL_NUM) + ADDR_W'(col_q);
  assign out_valid_o  = outValid;
  assign sel_right_o  = outWord.selRight;
  assign sel_left_o   = outWord.selLeft;
  assign merge_mask_o = outWord.mergeMask;
  assign out_null_o   = outWord.isNull;
  assign col_idx_o    = outWord.col;
  assign layer_idx_o  = outWord.layer;
  assign last_col_o   = outWord.lastCol;
  assign last_word_o  = outWord.lastWord;

endmodule
